// File: rtl/seg_scan_driver.sv
// seg_scan_driver: synchronizes a slow scan clock and multiplexes N hex digits onto a 7-segment display with anode blanking.
module seg_scan_driver #(
  parameter int N_DIGITS     = 8,
  parameter int BLANK_CYCLES = 4,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                        clk_in,
  input  logic                        rst,
  input  logic                        scan_clk,
  input  logic                        enable,
  input  logic                        lz_blank,
  input  logic [4*N_DIGITS-1:0]       digits_in,
  input  logic [N_DIGITS-1:0]         dp_in,
  output logic [N_DIGITS-1:0]         an,
  output logic [6:0]                  seg,
  output logic                        dp,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx
);
  localparam int IW = $clog2(N_DIGITS);
  localparam int CW = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES);
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef enum logic [1:0] {OFF, BLANK, ON} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [2:0]            s_q, s_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  rise, lz, on;
  logic [3:0]            nib;
  assign rise = s_q[1] & ~s_q[2];
  always_comb begin
    s_d     = {s_q[1:0], scan_clk};
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!enable) begin
      state_d = OFF;
    end else if (state_q == OFF) begin
      state_d = BLANK;
      cnt_d   = '0;
    end else if (rise) begin
      idx_d   = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
      state_d = BLANK;
      cnt_d   = '0;
    end else if (state_q == BLANK) begin
      state_d = (cnt_q == CW'(BLANK_CYCLES - 1)) ? ON : BLANK;
      cnt_d   = (cnt_q == CW'(BLANK_CYCLES - 1)) ? '0 : cnt_q + CW'(1);
    end
    // Outputs follow the next state so the dark window is exactly BLANK_CYCLES long.
    nib = 4'(digits_in >> {idx_d, 2'b00});
    lz  = lz_blank && (idx_d != '0);
    for (int i = 0; i < N_DIGITS; i++)
      if (i >= int'(idx_d) && digits_in[4*i +: 4] != 4'h0) lz = 1'b0;
    on   = (state_d == ON);
    an_d = ((on && !lz) ? (N_DIGITS'(1) << idx_d) : '0) ^ {N_DIGITS{POL}};
    seg_d = (on ? SEG_LUT[nib] : 7'h00) ^ {7{POL}};
    dp_d  = (on & dp_in[idx_d]) ^ POL;
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
      s_q     <= '0;
      an_q    <= {N_DIGITS{POL}};
      seg_q   <= {7{POL}};
      dp_q    <= POL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end
  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_idx = idx_q;
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Consumes the slow scan clock produced by the clock divider and drives a time-multiplexed N-digit 7-segment display.
- Treats scan_clk as data, not as a clock: synchronizes it into clk_in, detects rising edges, advances the digit slot, decodes hex to segments.
- Inserts an anode blanking gap on every slot change to prevent ghosting.
- Sits between the divider and the board display pins.

Parameters:
- N_DIGITS, 8, number of digits (2..16).
- BLANK_CYCLES, 4, clk_in cycles with all anodes off after each slot change (>=1).
- ACTIVE_LOW, 1, 1 = anodes/segments/dp driven active-low; 0 = active-high.

Ports:
- clk_in  input  1  system clock.
- rst  input  1  reset; synchronous to clk_in, active-high.
- scan_clk  input  1  divided scan clock from divider; asynchronous-safe level.
- enable  input  1  1 = scanning; 0 = display dark, index held.
- lz_blank  input  1  1 = suppress leading zeros.
- digits_in  input  4*N_DIGITS  hex nibbles; digit i = bits [4i+3:4i]; digit 0 = rightmost.
- dp_in  input  N_DIGITS  decimal point per digit.
- an  output  N_DIGITS  anode enables, one-hot or none.
- seg  output  7  segments {g,f,e,d,c,b,a}.
- dp  output  1  decimal point.
- digit_idx  output  clog2(N_DIGITS)  current slot index.

Behaviour:
- All outputs registered. "Inactive" means 1 if ACTIVE_LOW, else 0.
- Reset (rst=1 at a clk_in edge): an, seg, dp inactive; digit_idx=0; state=OFF; blank counter=0; sync flops=0.
- Synchronizer: scan_clk -> s1 -> s2 (2-flop sync), then s3 = delayed s2.
  - rise = s2 & ~s3.
  - The slot advance takes effect on the 3rd clk_in edge after scan_clk goes high.
- States: OFF, BLANK, ON.
- OFF:
  - an, seg, dp inactive.
  - enable=1 -> BLANK with counter=0; digit_idx unchanged, no advance.
- BLANK:
  - an all inactive; counter increments each cycle.
  - counter==BLANK_CYCLES-1 -> ON.
  - Anodes are therefore dark for exactly BLANK_CYCLES cycles.
- ON:
  - an[digit_idx] active, all other anodes inactive.
  - seg = decode(digits_in[digit_idx]); dp = dp_in[digit_idx].
  - Data is resampled every cycle with 1-cycle latency, so mid-slot data changes appear on the next cycle.
- rise with enable=1, in BLANK or ON:
  - digit_idx <= (digit_idx==N_DIGITS-1) ? 0 : digit_idx+1.
  - state <= BLANK; counter <= 0.
  - A rise during BLANK restarts blanking at the next index.
- enable=0 in any state: -> OFF next edge; outputs inactive; rises are ignored and do not advance digit_idx.
- Priority: rst > enable=0 > rise > counter expiry.
- Leading-zero blanking:
  - Applies when lz_blank=1, digit_idx>0, and every digit from digit_idx up to N_DIGITS-1 is 0.
  - In that slot, an stays inactive during ON.
  - Digit 0 is always shown.
- Decode, active-high form gfedcba before polarity inversion:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111.
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- If ACTIVE_LOW=1, an, seg and dp are bitwise inverted at the output register.

Test Plan:
- Reset/default: rst high 2 cycles with enable=1 -> an=8'hFF, seg=7'h7F, dp=1, digit_idx=0. One cycle after rst falls: BLANK. 4 cycles later: an=8'hFE, seg shows digits_in[3:0].
- Scan and wrap:
  - Stimulus: digits_in=32'h76543210, 8 scan_clk pulses.
  - Index steps 0..7 then 0.
  - Each rise gives exactly 4 dark cycles, then one-hot anode active low.
  - At idx 7, seg=~0000111=7'b1111000.
- Synchronizer latency: scan_clk rises between edges -> digit_idx changes on the 3rd clk_in edge after the rise. A scan_clk held high for 50 cycles advances only once.
- Rise during blanking: second rise 2 cycles after the first -> index advances twice; the dark period restarts; the anode re-enables 4 cycles after the second advance.
- Enable and leading zeros:
  - enable=0 mid-ON -> an=FF next cycle; 5 rises produce no index change. enable=1 -> BLANK at the same index.
  - lz_blank=1, digits_in=32'h00000305 -> slots 3..7 stay dark; slots 0..2 are lit; slot 1 shows 0 (not leading).
- Mid-operation reset: rst during ON at idx 5 -> next edge all outputs inactive, digit_idx=0.
